isqrt_range_reducer: RTL
========================

# isqrt_range_reducer

Operand range-reduction stage placed directly upstream of the Newton-Raphson reciprocal-square-root core. It accepts an unsigned Q1.(WL-1) operand and left-shifts it by an even number of bits until it lies in [0.5, 2), which is the NR core's LUT-valid range. It emits the reduced mantissa with shift count k, so that din = m·4^-k and rsqrt(din) = rsqrt(m)·2^k. The k output feeds the downstream rescaling stage.

## Interface
- WL, 24: operand word length; Q1.(WL-1) unsigned; must be even.
- KW, $clog2(WL/2): width of shift-count output.
- CLK, in, 1: clock; all state updates on rising edge.
- RST, in, 1: reset; **synchronous, active-high**.
- CE, in, 1: clock enable; when low, all registers hold and no handshake completes.
- din, in, WL: operand, unsigned Q1.(WL-1).
- in_valid, in, 1: din valid.
- in_ready, out, 1: block can accept; = CE && state==IDLE.
- m_out, out, WL: reduced mantissa, Q1.(WL-1), in [0.5, 2) unless zero.
- k_out, out, KW: even-shift count (shift = 2·k_out bits), 0..(WL-2)/2.
- zero_out, out, 1: operand was zero; rsqrt undefined.
- out_valid, out, 1: m_out/k_out/zero_out valid.
- out_ready, in, 1: downstream accepts.

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - On CE && in_valid && in_ready, register din into the work register and clear k.
  - Next state is DONE with zero flag set if din==0, else SHIFT.
- SHIFT, evaluated once per CE cycle:
  - If work[WL-1:WL-2]==2'b00: shift work left by 2 (zero-fill), k<=k+1, stay in SHIFT.
  - Otherwise: m_out<=work, k_out<=k, out_valid<=1, go to DONE.
- DONE:
  - Hold m_out, k_out, zero_out and out_valid stable.
  - On CE && out_ready: out_valid<=0, go to IDLE.
- Zero operand: m_out=0, k_out=0, zero_out=1. Never enters SHIFT, so the shift loop cannot run away.
- Arithmetic:
  - Left shifts only; no bits are lost, since termination occurs before any set bit reaches the MSB.
  - k never exceeds (WL-2)/2; for WL=24, k≤11.
- Throughput: one operand in flight. in_ready is low in SHIFT and DONE, so in_valid there is ignored and the upstream must hold din.
- CE low in any state freezes the FSM, work register and outputs. in_ready reads 0 while CE is low.

## Timing
- Reset values: state=IDLE, out_valid=0, m_out=0, k_out=0, zero_out=0. in_ready=1 whenever CE=1 after reset.
- Reset mid-operation (SHIFT or DONE): the operand is discarded. out_valid=0 on the next edge and no output transfer occurs.
- Latency is counted from the accepting edge N, with CE continuously high:
  - Nonzero operand: out_valid rises at edge N+k+1. Worst case is WL/2 cycles (12 for WL=24).
  - Zero operand: out_valid rises at edge N+1.
- Output transfer at edge T (out_valid && out_ready && CE): in_ready=1 after T. The next accept is no earlier than T+1. There is no combinational path from in_valid to out_valid or in_ready.
- out_ready held low: outputs stay bit-stable indefinitely.

## Structure
- Shared package isqrt_pkg holds the following, so the NR core and the rescaling stage use identical definitions:
  - localparams WL and KW.
  - state enum {IDLE, SHIFT, DONE}.
  - Q-format constants ONE_HALF = 1<<(WL-2) and MAX_K = (WL-2)/2.
- No sub-module: the top-pair zero test and the 2-bit shift are inline. Expected RTL is about 150 lines.

## Test plan
- din=0x600000 (0.75) -> m_out=0x600000, k_out=0, zero_out=0, out_valid at N+1.
- din=0x100000 (0.125) -> m_out=0x400000, k_out=1, out_valid at N+2.
- din=0x000001 -> m_out=0x400000, k_out=11, out_valid at N+12. Separately, din=0x000003 -> m_out=0xC00000, k_out=11.
- din=0x000000 -> zero_out=1, m_out=0, k_out=0, out_valid at N+1.
- Backpressure and CE:
  - Hold out_ready=0 for 5 cycles with a second in_valid pending -> outputs stable, in_ready=0, second operand not accepted until after the transfer.
  - Drop CE for 3 cycles mid-SHIFT -> latency extends by exactly 3 cycles.
- Assert RST for one cycle during SHIFT of din=0x000001 -> next cycle out_valid=0 and in_ready=1. A fresh din=0x600000 then completes normally with k_out=0.

Source files
------------

// File: rtl/isqrt_pkg.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_pkg
// Description : Shared definitions for the reciprocal-square-root datapath.
// Revision    : 1.0 - initial release
// ============================================================================
package isqrt_pkg;

    localparam int WL = 24;
    localparam int KW = $clog2(WL / 2);

    localparam logic [WL-1:0] ONE_HALF = WL'(1) << (WL - 2);
    localparam logic [KW-1:0] MAX_K    = KW'((WL - 2) / 2);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/isqrt_range_reducer.sv
`default_nettype none
// ============================================================================
// Module      : isqrt_range_reducer
// Description : Even left-shift normaliser into [0.5, 2) ahead of the NR core.
// Revision    : 1.0 - initial release
// ============================================================================
module isqrt_range_reducer
    import isqrt_pkg::*;
(
    input  logic          CLK,
    input  logic          RST,
    input  logic          CE,
    input  logic [WL-1:0] din,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [WL-1:0] m_out,
    output logic [KW-1:0] k_out,
    output logic          zero_out,
    output logic          out_valid,
    input  logic          out_ready
);

    state_t        r_state;
    logic [WL-1:0] r_work;
    logic [KW-1:0] r_k;

    assign in_ready = CE && (r_state == IDLE);

    always_ff @(posedge CLK) begin
        if (RST) begin
            r_state   <= IDLE;
            r_work    <= '0;
            r_k       <= '0;
            m_out     <= '0;
            k_out     <= '0;
            zero_out  <= 1'b0;
            out_valid <= 1'b0;
        end else if (CE) begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_work <= din;
                        r_k    <= '0;
                        if (din == '0) begin
                            // Zero bypasses the shift loop; result is
                            // staged here and presented one edge later.
                            m_out    <= '0;
                            k_out    <= '0;
                            zero_out <= 1'b1;
                            r_state  <= DONE;
                        end else begin
                            zero_out <= 1'b0;
                            r_state  <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    if (r_work[WL-1 -: 2] == 2'b00) begin
                        r_work <= {r_work[WL-3:0], 2'b00};
                        r_k    <= r_k + 1'b1;
                    end else begin
                        m_out     <= r_work;
                        k_out     <= r_k;
                        out_valid <= 1'b1;
                        r_state   <= DONE;
                    end
                end
                DONE: begin
                    if (!out_valid) begin
                        out_valid <= 1'b1;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
`default_nettype wire
